// File: rtl/hyper_lsab_cw.sv
// hyper_lsab_cw: four-section word buffer between the DRAM block mover and the device side, one shared RAM and a registered read port.
module hyper_lsab_cw #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 5,
  parameter int FULL_MARGIN = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  WRITE,
  input  logic [1:0]            WRITE_SECTION,
  input  logic [DATA_WIDTH-1:0] DATA_IN,
  input  logic                  READ,
  input  logic [1:0]            READ_SECTION,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  DATA_VALID,
  input  logic [3:0]            FLUSH,
  output logic                  FULL_0,
  output logic                  FULL_1,
  output logic                  FULL_2,
  output logic                  FULL_3,
  output logic                  EMPTY_0,
  output logic                  EMPTY_1,
  output logic                  EMPTY_2,
  output logic                  EMPTY_3,
  output logic                  OVERFLOW_0,
  output logic                  OVERFLOW_1,
  output logic                  OVERFLOW_2,
  output logic                  OVERFLOW_3
);
  localparam int AW = DEPTH_LOG2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(1 << AW);
  localparam logic [AW:0] THR = (AW+1)'((1 << AW) - FULL_MARGIN);

  logic [DATA_WIDTH-1:0] mem [0:4*(1<<AW)-1];
  logic [AW-1:0] wptr [4];
  logic [AW-1:0] rptr [4];
  logic [AW:0] cnt [4];
  logic [AW:0] cnt_nxt [4];
  logic [3:0] we, re, wr_hit, full, empty, ovf;

  assign {FULL_3, FULL_2, FULL_1, FULL_0} = full;
  assign {EMPTY_3, EMPTY_2, EMPTY_1, EMPTY_0} = empty;
  assign {OVERFLOW_3, OVERFLOW_2, OVERFLOW_1, OVERFLOW_0} = ovf;

  // Full/empty decisions use pre-edge counts; flush wins over both ports.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      wr_hit[n] = WRITE && WRITE_SECTION == 2'(n) && !FLUSH[n];
      we[n] = wr_hit[n] && cnt[n] != FULL_CNT;
      re[n] = READ && READ_SECTION == 2'(n) && !FLUSH[n] && cnt[n] != '0;
      cnt_nxt[n] = FLUSH[n] ? '0 : cnt[n] + (AW+1)'(we[n]) - (AW+1)'(re[n]);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      for (int n = 0; n < 4; n++) begin
        wptr[n] <= '0;
        rptr[n] <= '0;
        cnt[n] <= '0;
      end
      full <= '0;
      empty <= '1;
      ovf <= '0;
      DATA_OUT <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        cnt[n] <= cnt_nxt[n];
        full[n] <= cnt_nxt[n] >= THR;
        empty[n] <= cnt_nxt[n] == '0;
        if (FLUSH[n]) begin
          wptr[n] <= '0;
          rptr[n] <= '0;
          ovf[n] <= 1'b0;
        end else begin
          if (we[n]) wptr[n] <= wptr[n] + 1'b1;
          if (re[n]) rptr[n] <= rptr[n] + 1'b1;
          if (wr_hit[n] && !we[n]) ovf[n] <= 1'b1;
        end
      end
      DATA_VALID <= |re;
      if (|re) DATA_OUT <= mem[{READ_SECTION, rptr[READ_SECTION]}];
    end
  end

  always_ff @(posedge CLK)
    if (RST && |we) mem[{WRITE_SECTION, wptr[WRITE_SECTION]}] <= DATA_IN;
endmodule

// File: doc/hyper_lsab_cw.md
# hyper_lsab_cw

Four-section word buffer (LSAB, column-write side) that sits directly downstream of the DRAM-to-LSAB block mover. It captures DRAM words strobed in by the mover into one of four per-device sections, raises per-section FULL early enough for the mover to stop cleanly, and drains each section to the device side through a single shared, registered read port. Section state is independently flushable so that a device error on one section does not disturb the other three.

## Interface
- DATA_WIDTH, 32, width of one buffered word.
- DEPTH_LOG2, 5, log2 of words per section; section depth D = 2^DEPTH_LOG2.
- FULL_MARGIN, 8, FULL asserts when free space drops to this many words or fewer; must be ≥8 and < D.

- CLK  in  1  clock.
- RST  in  1  reset, synchronous, active-low.
- WRITE  in  1  write strobe from the mover; one word per asserted cycle.
- WRITE_SECTION  in  2  target section of WRITE.
- DATA_IN  in  DATA_WIDTH  word accompanying WRITE, the DRAM read data.
- READ  in  1  device-side read request, one word per asserted cycle.
- READ_SECTION  in  2  section to read.
- DATA_OUT  out  DATA_WIDTH  read data, registered.
- DATA_VALID  out  1  DATA_OUT holds a word popped on the previous edge.
- FLUSH  in  4  per-section flush, bit n flushes section n.
- FULL_0..FULL_3  out  1 each  section n occupancy ≥ D − FULL_MARGIN.
- EMPTY_0..EMPTY_3  out  1 each  section n occupancy = 0.
- OVERFLOW_0..OVERFLOW_3  out  1 each  sticky: a write to section n was dropped because it was full.

## Operation
- Storage: one RAM of 4·D words. Address = {section, pointer}. Per section: write pointer, read pointer (DEPTH_LOG2 bits, wrap mod D), occupancy count (DEPTH_LOG2+1 bits, range 0..D).
- Write: on an edge with WRITE=1, if count[WRITE_SECTION] < D, store DATA_IN at the write pointer, advance the pointer, and add 1 to the count. If count = D, drop the word, leave the pointer unchanged, and set OVERFLOW for that section.
- Read: on an edge with READ=1, if count[READ_SECTION] > 0, latch the word at the read pointer into DATA_OUT, advance the pointer, subtract 1 from the count, and set DATA_VALID=1. Otherwise DATA_OUT holds its value and DATA_VALID=0. There is no write-to-read bypass: reading an empty section in the same cycle as a write to it returns nothing.
- Simultaneous write and read to the same section, both legal: the count is unchanged and both pointers advance. Write to a full section with a simultaneous read of that section: the read is accepted and the write is dropped (the full test uses pre-edge count); OVERFLOW is set.
- Writes and reads to different sections are fully independent in the same cycle.
- FLUSH[n] takes priority over WRITE and READ targeting section n in the same cycle. It zeroes both pointers and the count and clears OVERFLOW_n. A read blocked by flush gives DATA_VALID=0.
- Flags are registered from the post-edge counts: FULL_n = (count ≥ D − FULL_MARGIN), EMPTY_n = (count = 0).
- Reset: all pointers and counts go to 0. DATA_OUT=0, DATA_VALID=0, FULL_n=0, EMPTY_n=1, OVERFLOW_n=0. RAM contents are not cleared. Reset mid-burst discards all buffered data.

## Timing
- Write at edge N: count and flags reflect it after edge N. The mover samples FULL at edge N+1 or later. The mover can issue up to 4 more writes after FULL is seen; FULL_MARGIN ≥ 8 guarantees no overflow under correct mover behaviour.
- Read latency is 1 cycle: READ at edge N gives DATA_OUT/DATA_VALID valid after edge N, for one cycle only unless READ is held.
- Sustained throughput is 1 write + 1 read per cycle, with no bubbles across pointer wrap.
- FLUSH takes effect at the edge it is sampled; flags are updated by that same edge.

## Test plan
- Reset, then idle: all EMPTY_n=1, FULL_n=0, OVERFLOW_n=0, DATA_VALID=0, DATA_OUT=0.
- Write 0x100..0x117 (24 words) to section 2 -> FULL_2 rises the cycle after the 24th write. Read 24 times -> DATA_OUT 0x100..0x117 in order, DATA_VALID high for 24 cycles, EMPTY_2=1 after the last read.
- Fill section 1 with 32 words, then write a 33rd word 0xDEAD -> word dropped, OVERFLOW_1=1, count stays 32. Read 32 words -> 0xDEAD never appears. FLUSH[1] -> OVERFLOW_1=0, EMPTY_1=1.
- Stream 100 words to section 0 while reading section 0 every cycle starting 2 cycles after the first write -> in-order data across 3 pointer wraps, FULL_0 never asserts.
- Same-cycle write to section 3 (empty) and read of section 3 -> DATA_VALID=0. On the next cycle, a read of section 3 returns the word.
- Assert RST low mid-stream with 10 words in section 0 and 5 in section 3 -> all counts 0, EMPTY_n=1, and the next read returns DATA_VALID=0.
